// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared widths and types for the 8:1 select primitive
package mux_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_IN-1:0]  lanes_t;

endpackage

// File: rtl/mux_2_1.sv
// rtl/mux_2_1.sv - single-bit 2:1 select, the leaf of the 8:1 tree
module mux_2_1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux_8_1.sv
// rtl/mux_8_1.sv - 8:1 one-bit mux built as a 3-level 2:1 tree, plus a flopped copy
module mux_8_1
  import mux_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  sel_t   sel,
  input  lanes_t i,
  output logic   f,
  output logic   f_q
);

  logic [3:0] lvl0;
  logic [1:0] lvl1;

  // level 0: adjacent lane pairs resolved by sel[0]
  mux_2_1 u_l0_0 (.a(i[0]), .b(i[1]), .s(sel[0]), .y(lvl0[0]));
  mux_2_1 u_l0_1 (.a(i[2]), .b(i[3]), .s(sel[0]), .y(lvl0[1]));
  mux_2_1 u_l0_2 (.a(i[4]), .b(i[5]), .s(sel[0]), .y(lvl0[2]));
  mux_2_1 u_l0_3 (.a(i[6]), .b(i[7]), .s(sel[0]), .y(lvl0[3]));

  mux_2_1 u_l1_0 (.a(lvl0[0]), .b(lvl0[1]), .s(sel[1]), .y(lvl1[0]));
  mux_2_1 u_l1_1 (.a(lvl0[2]), .b(lvl0[3]), .s(sel[1]), .y(lvl1[1]));

  mux_2_1 u_l2_0 (.a(lvl1[0]), .b(lvl1[1]), .s(sel[2]), .y(f));

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= 1'b0;
    end else begin
      f_q <= f;
    end
  end

endmodule

// File: tb/tb_mux_8_1.sv
// tb/tb_mux_8_1.sv - directed vector bench for mux_8_1
module tb_mux_8_1;
  import mux_pkg::*;

  logic   clk;
  logic   rst;
  sel_t   sel;
  lanes_t i;
  logic   f;
  logic   f_q;

  int checks = 0;
  int errors = 0;

  mux_8_1 dut (
    .clk (clk),
    .rst (rst),
    .sel (sel),
    .i   (i),
    .f   (f),
    .f_q (f_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    sel_t   sel;
    lanes_t i;
    logic   f;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input sel_t s, input lanes_t l, input logic e);
    vec_t v;
    v.sel = s;
    v.i   = l;
    v.f   = e;
    return v;
  endfunction

  initial begin
    lanes_t oh;
    rst = 1'b1;
    sel = '0;
    i   = '0;

    vecs.push_back(mk(3'b000, 8'b0000_0001, 1'b1));
    vecs.push_back(mk(3'b000, 8'b0000_0000, 1'b0));
    vecs.push_back(mk(3'b110, 8'b0000_0000, 1'b0));
    vecs.push_back(mk(3'b110, 8'b0100_0000, 1'b1));
    vecs.push_back(mk(3'b110, 8'b0001_0000, 1'b0));
    vecs.push_back(mk(3'b010, 8'b1111_1011, 1'b0));
    vecs.push_back(mk(3'b111, 8'b1000_0000, 1'b1));
    for (int k = 0; k < 8; k++) begin
      oh = lanes_t'(1) << k;
      vecs.push_back(mk(sel_t'(k), oh, 1'b1));
      vecs.push_back(mk(sel_t'(k), ~oh, 1'b0));
    end

    foreach (vecs[n]) begin
      sel = vecs[n].sel;
      i   = vecs[n].i;
      #1;
      check($sformatf("vec%0d_sel%0d_i%02h", n, vecs[n].sel, vecs[n].i), f, vecs[n].f);
    end

    // registered path: reset, one-edge latency, follow-to-zero
    rst = 1'b1;
    tick();
    tick();
    check("reset_fq", f_q, 1'b0);
    rst = 1'b0;
    sel = 3'b011;
    i   = 8'b0000_1000;
    #1;
    check("fq_before_edge", f_q, 1'b0);
    check("f_lane3", f, 1'b1);
    tick();
    check("fq_lane3_one_edge", f_q, 1'b1);
    i = 8'b0000_0000;
    #1;
    check("fq_holds_until_edge", f_q, 1'b1);
    check("f_zero_immediate", f, 1'b0);
    tick();
    check("fq_zero_one_edge", f_q, 1'b0);

    // reset mid-operation overrides a live 1 on the data path
    sel = 3'b111;
    i   = 8'b1000_0000;
    tick();
    check("fq_lane7", f_q, 1'b1);
    rst = 1'b1;
    tick();
    check("fq_mid_reset", f_q, 1'b0);
    check("f_during_reset", f, 1'b1);
    rst = 1'b0;
    tick();
    check("fq_after_reset", f_q, 1'b1);

    // unselected-lane isolation
    sel = 3'b101;
    for (int s = 0; s < 50; s++) begin
      i = lanes_t'($urandom) | 8'b0010_0000;
      #1;
      check($sformatf("isolate_step%0d_i%02h", s, i), f, 1'b1);
    end
    tick();
    check("fq_isolate", f_q, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
